// File: rtl/c_pipe_ctrl_if.sv
// c_pipe_ctrl_if: signal bundle between the hazard/decode side and the
// control-word pipeline.
//
// Handshake: in_valid marks in_ctrl as a real instruction. A word is taken
// into stage 0 at a rising clk edge where in_ready=1 and flush[0]=0. When
// in_ready=0 the word is not taken and the producer must keep presenting it.
// in_ready depends only on stall, never on in_valid.
//
// Signals:
//   in_ctrl/in_valid    decode -> pipe, control word and its valid bit
//   stall/flush         hazard unit -> pipe, one bit per stage
//   in_ready            pipe -> decode, stage 0 can load this cycle
//   out_ctrl/out_valid  last stage contents
//   stage_valid         valid bit of every stage
//   occupancy           number of valid stages
//   bubble_cnt          saturating count of edges that saw out_valid=0
interface c_pipe_ctrl_if #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 1,
  parameter int CNT_W = 16
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] in_ctrl;
  logic             in_valid;
  logic [DEPTH-1:0] stall;
  logic [DEPTH-1:0] flush;
  logic             in_ready;
  logic [WIDTH-1:0] out_ctrl;
  logic             out_valid;
  logic [DEPTH-1:0] stage_valid;
  logic [OCC_W-1:0] occupancy;
  logic [CNT_W-1:0] bubble_cnt;

  modport master (
    output in_ctrl, in_valid, stall, flush,
    input  in_ready, out_ctrl, out_valid, stage_valid, occupancy, bubble_cnt
  );

  modport slave (
    input  in_ctrl, in_valid, stall, flush,
    output in_ready, out_ctrl, out_valid, stage_valid, occupancy, bubble_cnt
  );
endinterface

// File: rtl/c_pipe_ctrl.sv
// c_pipe_ctrl: DEPTH-stage pipeline register for the packed control word
// between decode and execute/memory/writeback. Each stage has a valid bit,
// per-stage stall and flush, hold propagation toward the front of the pipe
// and automatic bubble insertion behind a held stage. Also reports
// occupancy and a saturating count of bubble cycles at the output.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-low reset
//   bus    c_pipe_ctrl_if.slave (see the interface for signal meanings)
module c_pipe_ctrl #(
  parameter int               WIDTH     = 12,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] CLEAR_VAL = '0,
  parameter int               CNT_W     = 16
) (
  input  logic          clk,
  input  logic          reset,
  c_pipe_ctrl_if.slave  bus
);
  localparam int               OCC_W   = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] r_ctrl [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [OCC_W-1:0] r_occ;
  logic [CNT_W-1:0] r_bubble_cnt;

  logic [DEPTH-1:0] w_hold;
  logic [WIDTH-1:0] w_ctrl_nxt [DEPTH];
  logic [DEPTH-1:0] w_valid_nxt;
  logic [OCC_W-1:0] w_occ_nxt;

  // A stage holds if it or any stage downstream of it is stalled: shifting
  // stall right by k leaves exactly the bits k..DEPTH-1.
  always_comb begin
    w_hold = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_hold[k] = |(bus.stall >> k);
    end
  end

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      w_ctrl_nxt[k]  = r_ctrl[k];
      w_valid_nxt[k] = r_valid[k];
    end

    // Stage 0: an invalid input word is stored as CLEAR_VAL.
    if (bus.flush[0]) begin
      w_ctrl_nxt[0]  = CLEAR_VAL;
      w_valid_nxt[0] = 1'b0;
    end else if (!w_hold[0]) begin
      w_ctrl_nxt[0]  = bus.in_valid ? bus.in_ctrl : CLEAR_VAL;
      w_valid_nxt[0] = bus.in_valid;
    end

    for (int k = 1; k < DEPTH; k++) begin
      if (bus.flush[k]) begin
        w_ctrl_nxt[k]  = CLEAR_VAL;
        w_valid_nxt[k] = 1'b0;
      end else if (w_hold[k]) begin
        w_ctrl_nxt[k]  = r_ctrl[k];
        w_valid_nxt[k] = r_valid[k];
      end else if (w_hold[k-1]) begin
        // Upstream neighbour is frozen: take a bubble rather than a copy.
        w_ctrl_nxt[k]  = CLEAR_VAL;
        w_valid_nxt[k] = 1'b0;
      end else begin
        w_ctrl_nxt[k]  = r_ctrl[k-1];
        w_valid_nxt[k] = r_valid[k-1];
      end
    end
  end

  always_comb begin
    w_occ_nxt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_occ_nxt = w_occ_nxt + OCC_W'(w_valid_nxt[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_ctrl[k] <= CLEAR_VAL;
      end
      r_valid      <= '0;
      r_occ        <= '0;
      r_bubble_cnt <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        r_ctrl[k] <= w_ctrl_nxt[k];
      end
      r_valid <= w_valid_nxt;
      r_occ   <= w_occ_nxt;
      // Counts edges that see the registered output empty; sticks at max.
      if (!r_valid[DEPTH-1] && (r_bubble_cnt != CNT_MAX)) begin
        r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready    = ~w_hold[0];
  assign bus.out_ctrl    = r_ctrl[DEPTH-1];
  assign bus.out_valid   = r_valid[DEPTH-1];
  assign bus.stage_valid = r_valid;
  assign bus.occupancy   = r_occ;
  assign bus.bubble_cnt  = r_bubble_cnt;
endmodule

// File: tb/tb_c_pipe_ctrl.sv
// Bench for c_pipe_ctrl: five configurations share one stimulus stream
// (stall/flush take the low DEPTH bits of shared 8-bit vectors). A model of
// the stage contents is updated at every rising edge and compared against
// every instance on each falling edge; directed sequences add literal checks.
module tb_c_pipe_ctrl;
  localparam int NI = 5;
  localparam int DEP[NI] = '{3, 2, 1, 1, 8};
  localparam logic [11:0] CLR[NI] = '{12'h000, 12'h800, 12'h000, 12'h800, 12'h5A5};
  localparam int CMAX[NI] = '{15, 65535, 65535, 65535, 65535};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic [11:0] in_ctrl = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  stall = '0;
  logic [7:0]  flush = '0;

  // ---------------- DUT instances ----------------
  c_pipe_ctrl_if #(.WIDTH(12), .DEPTH(3), .CNT_W(4))  if0();
  c_pipe_ctrl_if #(.WIDTH(12), .DEPTH(2), .CNT_W(16)) if1();
  c_pipe_ctrl_if #(.WIDTH(12), .DEPTH(1), .CNT_W(16)) if2();
  c_pipe_ctrl_if #(.WIDTH(12), .DEPTH(1), .CNT_W(16)) if3();
  c_pipe_ctrl_if #(.WIDTH(12), .DEPTH(8), .CNT_W(16)) if4();

  assign if0.in_ctrl = in_ctrl; assign if0.in_valid = in_valid;
  assign if0.stall = stall[2:0]; assign if0.flush = flush[2:0];
  assign if1.in_ctrl = in_ctrl; assign if1.in_valid = in_valid;
  assign if1.stall = stall[1:0]; assign if1.flush = flush[1:0];
  assign if2.in_ctrl = in_ctrl; assign if2.in_valid = in_valid;
  assign if2.stall = stall[0:0]; assign if2.flush = flush[0:0];
  assign if3.in_ctrl = in_ctrl; assign if3.in_valid = in_valid;
  assign if3.stall = stall[0:0]; assign if3.flush = flush[0:0];
  assign if4.in_ctrl = in_ctrl; assign if4.in_valid = in_valid;
  assign if4.stall = stall;      assign if4.flush = flush;

  c_pipe_ctrl #(.WIDTH(12), .DEPTH(3), .CLEAR_VAL(12'h000), .CNT_W(4))
    u0 (.clk(clk), .reset(rst_n), .bus(if0));
  c_pipe_ctrl #(.WIDTH(12), .DEPTH(2), .CLEAR_VAL(12'h800), .CNT_W(16))
    u1 (.clk(clk), .reset(rst_n), .bus(if1));
  c_pipe_ctrl #(.WIDTH(12), .DEPTH(1), .CLEAR_VAL(12'h000), .CNT_W(16))
    u2 (.clk(clk), .reset(rst_n), .bus(if2));
  c_pipe_ctrl #(.WIDTH(12), .DEPTH(1), .CLEAR_VAL(12'h800), .CNT_W(16))
    u3 (.clk(clk), .reset(rst_n), .bus(if3));
  c_pipe_ctrl #(.WIDTH(12), .DEPTH(8), .CLEAR_VAL(12'h5A5), .CNT_W(16))
    u4 (.clk(clk), .reset(rst_n), .bus(if4));

  // Uniform views of the outputs of every instance.
  logic [11:0] a_ctrl[NI];
  logic        a_valid[NI];
  logic [7:0]  a_sv[NI];
  logic [3:0]  a_occ[NI];
  logic [15:0] a_cnt[NI];
  logic        a_ready[NI];

  assign a_ctrl[0] = if0.out_ctrl; assign a_valid[0] = if0.out_valid;
  assign a_sv[0] = 8'(if0.stage_valid); assign a_occ[0] = 4'(if0.occupancy);
  assign a_cnt[0] = 16'(if0.bubble_cnt); assign a_ready[0] = if0.in_ready;
  assign a_ctrl[1] = if1.out_ctrl; assign a_valid[1] = if1.out_valid;
  assign a_sv[1] = 8'(if1.stage_valid); assign a_occ[1] = 4'(if1.occupancy);
  assign a_cnt[1] = if1.bubble_cnt; assign a_ready[1] = if1.in_ready;
  assign a_ctrl[2] = if2.out_ctrl; assign a_valid[2] = if2.out_valid;
  assign a_sv[2] = 8'(if2.stage_valid); assign a_occ[2] = 4'(if2.occupancy);
  assign a_cnt[2] = if2.bubble_cnt; assign a_ready[2] = if2.in_ready;
  assign a_ctrl[3] = if3.out_ctrl; assign a_valid[3] = if3.out_valid;
  assign a_sv[3] = 8'(if3.stage_valid); assign a_occ[3] = 4'(if3.occupancy);
  assign a_cnt[3] = if3.bubble_cnt; assign a_ready[3] = if3.in_ready;
  assign a_ctrl[4] = if4.out_ctrl; assign a_valid[4] = if4.out_valid;
  assign a_sv[4] = if4.stage_valid; assign a_occ[4] = 4'(if4.occupancy);
  assign a_cnt[4] = if4.bubble_cnt; assign a_ready[4] = if4.in_ready;

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s u%0d: got 0x%0h, expected 0x%0h at %0t", name, idx, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [11:0] m_ctrl[NI][8];
  logic        m_valid[NI][8];
  int          m_cnt[NI];
  bit          model_live = 1'b0;

  // Highest stalled stage inside this instance, -1 when none. Every stage at
  // or below it is frozen; the stage right after it receives a bubble.
  function automatic int top_stall(input int i);
    int h = -1;
    for (int k = 0; k < DEP[i]; k++) if (stall[k]) h = k;
    return h;
  endfunction

  task automatic model_step();
    for (int i = 0; i < NI; i++) begin
      int d;
      int h;
      logic [11:0] oc[8];
      logic        ov[8];
      d = DEP[i];
      if (!rst_n) begin
        for (int k = 0; k < 8; k++) begin
          m_ctrl[i][k]  = CLR[i];
          m_valid[i][k] = 1'b0;
        end
        m_cnt[i] = 0;
      end else begin
        if (!m_valid[i][d-1] && m_cnt[i] < CMAX[i]) m_cnt[i]++;
        for (int k = 0; k < 8; k++) begin
          oc[k] = m_ctrl[i][k];
          ov[k] = m_valid[i][k];
        end
        h = top_stall(i);
        for (int k = 0; k < d; k++) begin
          if (flush[k]) begin
            m_ctrl[i][k] = CLR[i]; m_valid[i][k] = 1'b0;
          end else if (k <= h) begin
            m_ctrl[i][k] = oc[k]; m_valid[i][k] = ov[k];
          end else if (h >= 0 && k == h + 1) begin
            m_ctrl[i][k] = CLR[i]; m_valid[i][k] = 1'b0;
          end else if (k == 0) begin
            m_ctrl[i][k] = in_valid ? in_ctrl : CLR[i]; m_valid[i][k] = in_valid;
          end else begin
            m_ctrl[i][k] = oc[k-1]; m_valid[i][k] = ov[k-1];
          end
        end
      end
    end
    if (!rst_n) model_live = 1'b1;
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (model_live) begin
      for (int i = 0; i < NI; i++) begin
        automatic int d = DEP[i];
        automatic logic [7:0] esv = '0;
        automatic int eocc = 0;
        for (int k = 0; k < d; k++) begin
          esv[k] = m_valid[i][k];
          eocc += int'(m_valid[i][k]);
        end
        check("out_ctrl", i, 32'(a_ctrl[i]), 32'(m_ctrl[i][d-1]));
        check("out_valid", i, 32'(a_valid[i]), 32'(m_valid[i][d-1]));
        check("stage_valid", i, 32'(a_sv[i]), 32'(esv));
        check("occupancy", i, 32'(a_occ[i]), 32'(eocc));
        check("bubble_cnt", i, 32'(a_cnt[i]), 32'(m_cnt[i]));
        check("in_ready", i, 32'(a_ready[i]), 32'(top_stall(i) < 0));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic cycle(input logic r, input logic [11:0] c, input logic v,
                       input logic [7:0] s, input logic [7:0] f);
    rst_n = r; in_ctrl = c; in_valid = v; stall = s; flush = f;
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    // Reset and fill (u0, DEPTH=3).
    cycle(1'b0, 12'h000, 1'b0, 8'h00, 8'h00);
    cycle(1'b0, 12'h000, 1'b0, 8'h00, 8'h00);
    check("rst_sv", 0, 32'(a_sv[0]), 32'h0);
    check("rst_cnt", 0, 32'(a_cnt[0]), 32'h0);
    check("rst_ready", 0, 32'(a_ready[0]), 32'h1);
    cycle(1'b1, 12'h0A1, 1'b1, 8'h00, 8'h00);
    check("fill1_valid", 0, 32'(a_valid[0]), 32'h0);
    cycle(1'b1, 12'h0A2, 1'b1, 8'h00, 8'h00);
    cycle(1'b1, 12'h0A3, 1'b1, 8'h00, 8'h00);
    check("fill_ctrl_a1", 0, 32'(a_ctrl[0]), 32'h0A1);
    check("fill_valid_a1", 0, 32'(a_valid[0]), 32'h1);
    check("fill_cnt", 0, 32'(a_cnt[0]), 32'h3);
    check("fill_occ", 0, 32'(a_occ[0]), 32'h3);

    // Mid-pipe stall (u0).
    cycle(1'b1, 12'h011, 1'b1, 8'h00, 8'h00);
    check("fill_ctrl_a2", 0, 32'(a_ctrl[0]), 32'h0A2);
    cycle(1'b1, 12'h022, 1'b1, 8'h00, 8'h00);
    check("fill_ctrl_a3", 0, 32'(a_ctrl[0]), 32'h0A3);
    cycle(1'b1, 12'h033, 1'b1, 8'h00, 8'h00);
    check("stall_pre", 0, 32'(a_ctrl[0]), 32'h011);
    for (int n = 0; n < 2; n++) begin
      cycle(1'b1, 12'h044, 1'b1, 8'h02, 8'h00);
      check("stall_ready", 0, 32'(a_ready[0]), 32'h0);
      check("stall_bubble_ctrl", 0, 32'(a_ctrl[0]), 32'h000);
      check("stall_bubble_valid", 0, 32'(a_valid[0]), 32'h0);
      check("stall_sv", 0, 32'(a_sv[0]), 32'h3);
    end
    cycle(1'b1, 12'h044, 1'b1, 8'h00, 8'h00);
    check("resume_022", 0, 32'(a_ctrl[0]), 32'h022);
    cycle(1'b1, 12'h055, 1'b1, 8'h00, 8'h00);
    check("resume_033", 0, 32'(a_ctrl[0]), 32'h033);
    cycle(1'b1, 12'h000, 1'b0, 8'h00, 8'h00);
    check("resume_044", 0, 32'(a_ctrl[0]), 32'h044);

    // Flush over stall (u1, DEPTH=2, CLEAR_VAL=0x800).
    cycle(1'b1, 12'h155, 1'b1, 8'h00, 8'h00);
    cycle(1'b1, 12'h1AA, 1'b1, 8'h00, 8'h00);
    check("fos_pre", 1, 32'(a_ctrl[1]), 32'h155);
    cycle(1'b1, 12'h2BB, 1'b1, 8'h02, 8'h02);
    check("fos_valid", 1, 32'(a_valid[1]), 32'h0);
    check("fos_ctrl", 1, 32'(a_ctrl[1]), 32'h800);
    check("fos_sv", 1, 32'(a_sv[1]), 32'h1);
    cycle(1'b1, 12'h2BB, 1'b1, 8'h00, 8'h00);
    check("fos_frozen", 1, 32'(a_ctrl[1]), 32'h1AA);

    // Reset while full and stalled.
    for (int n = 0; n < 8; n++) cycle(1'b1, 12'h3FF, 1'b1, 8'h00, 8'h00);
    cycle(1'b1, 12'h3FF, 1'b1, 8'hFF, 8'h00);
    check("full_occ", 4, 32'(a_occ[4]), 32'h8);
    cycle(1'b0, 12'h3FF, 1'b1, 8'hFF, 8'h00);
    check("mrst_sv", 0, 32'(a_sv[0]), 32'h0);
    check("mrst_ctrl", 0, 32'(a_ctrl[0]), 32'h000);
    check("mrst_occ", 0, 32'(a_occ[0]), 32'h0);
    check("mrst_cnt", 0, 32'(a_cnt[0]), 32'h0);
    check("mrst_ctrl8", 4, 32'(a_ctrl[4]), 32'h5A5);

    // Saturation (u0, CNT_W=4) and invalid-input masking (u2, u3).
    for (int n = 1; n <= 20; n++) begin
      cycle(1'b1, 12'hFFF, 1'b0, 8'h00, 8'h00);
      if (n == 1) begin
        check("mask_ctrl_c0", 2, 32'(a_ctrl[2]), 32'h000);
        check("mask_valid", 2, 32'(a_valid[2]), 32'h0);
        check("mask_ctrl_c800", 3, 32'(a_ctrl[3]), 32'h800);
      end
      if (n == 14) check("sat_14", 0, 32'(a_cnt[0]), 32'd14);
      if (n == 20) check("sat_hold", 0, 32'(a_cnt[0]), 32'd15);
    end

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] s;
      logic [7:0] f;
      s = '0;
      f = '0;
      for (int b = 0; b < 8; b++) begin
        s[b] = ($urandom_range(0, 9) == 0);
        f[b] = ($urandom_range(0, 19) == 0);
      end
      cycle(($urandom_range(0, 99) != 0), 12'($urandom),
            ($urandom_range(0, 3) != 0), s, f);
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
